// File: rtl/monitor_seq_if.sv
// Pin-side bundle of the monitor sequencer: arm/clear/config requests, the monitor's
// valid level, and the monitor reset/config plus health status coming back.
interface monitor_seq_if #(
  parameter int EVT_W = 4
);
  // No valid/ready handshake here: arm and valid are levels (valid low = transient),
  // clear is a single-cycle pulse, and every output is a registered level.
  logic             arm;
  logic             clear;
  logic [3:0]       compare_cfg;
  logic             valid;
  logic             monitor_rst;
  logic [3:0]       compare;
  logic             ok;
  logic             fault;
  logic [EVT_W-1:0] event_cnt;
  logic [2:0]       state;

  modport master (
    output arm, clear, compare_cfg, valid,
    input  monitor_rst, compare, ok, fault, event_cnt, state
  );

  modport slave (
    input  arm, clear, compare_cfg, valid,
    output monitor_rst, compare, ok, fault, event_cnt, state
  );
endinterface

// File: rtl/monitor_sequencer.sv
// Sequences one state_monitor channel through disarm, blanking, monitoring, hold and fault.
// Optional MONITOR_SEQ_AUTORETRY_EN: re-arm automatically from FAULT once valid is steady.
module monitor_sequencer #(
  parameter int               CNT_W         = 16,
  parameter logic [CNT_W-1:0] BLANK_CYCLES  = 16'd10000,
  parameter logic [CNT_W-1:0] WINDOW_CYCLES = 16'd50000,
  parameter int               EVT_W         = 4,
  parameter logic [EVT_W-1:0] MAX_EVENTS    = 4'd3
) (
  input logic           i_clk,
  input logic           i_reset,
  monitor_seq_if.slave  bus
);

  localparam logic [2:0] ST_DISARMED = 3'd0;
  localparam logic [2:0] ST_ARMING   = 3'd1;
  localparam logic [2:0] ST_MONITOR  = 3'd2;
  localparam logic [2:0] ST_HOLD     = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  localparam logic [CNT_W-1:0] BLANK_LD  = BLANK_CYCLES - 1'b1;
  localparam logic [CNT_W-1:0] WINDOW_LD = WINDOW_CYCLES - 1'b1;
`ifdef MONITOR_SEQ_AUTORETRY_EN
  localparam logic [CNT_W-1:0] FAULT_LD  = WINDOW_LD;
`else
  localparam logic [CNT_W-1:0] FAULT_LD  = '0;
`endif

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] timer, timer_n, timer_w;
  logic             win_run, win_n, win_w;
  logic [EVT_W-1:0] cnt, cnt_n, cnt_w, cnt_inc;
  logic [3:0]       cmp, cmp_n;
  logic             monitor_rst_q, ok_q, fault_q;
  logic             expire;

  assign expire = win_run && (timer == '0);

  always_comb begin
    state_n = state;
    timer_n = timer;
    win_n   = win_run;
    cnt_n   = cnt;
    cmp_n   = cmp;
    // Window bookkeeping is applied before the event so expiry wins a same-cycle tie.
    cnt_w   = expire ? '0 : cnt;
    win_w   = win_run && !expire;
    timer_w = win_w ? timer - 1'b1 : timer;
    cnt_inc = (cnt_w < MAX_EVENTS) ? cnt_w + 1'b1 : cnt_w;

    case (state)
      ST_DISARMED: begin
        timer_n = '0;
        win_n   = 1'b0;
        cnt_n   = '0;
        if (bus.arm) begin
          state_n = ST_ARMING;
          cmp_n   = bus.compare_cfg;
          timer_n = BLANK_LD;
        end
      end
      ST_ARMING: begin
        if (!bus.arm) begin
          state_n = ST_DISARMED;
          timer_n = '0;
          win_n   = 1'b0;
          cnt_n   = '0;
        end else if (timer == '0) begin
          state_n = ST_MONITOR;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      ST_MONITOR, ST_HOLD: begin
        if (!bus.arm) begin
          state_n = ST_DISARMED;
          timer_n = '0;
          win_n   = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt_w;
          win_n   = win_w;
          timer_n = timer_w;
          if (state == ST_MONITOR && !bus.valid) begin
            cnt_n = cnt_inc;
            if (cnt_inc == MAX_EVENTS) begin
              state_n = ST_FAULT;
              win_n   = 1'b0;
              timer_n = FAULT_LD;
            end else begin
              state_n = ST_HOLD;
              if (!win_w) begin
                win_n   = 1'b1;
                timer_n = WINDOW_LD;
              end
            end
          end else if (state == ST_HOLD && bus.valid) begin
            state_n = ST_MONITOR;
          end
        end
      end
      ST_FAULT: begin
        if (bus.clear) begin
          cnt_n = '0;
          win_n = 1'b0;
          if (bus.arm) begin
            state_n = ST_ARMING;
            cmp_n   = bus.compare_cfg;
            timer_n = BLANK_LD;
          end else begin
            state_n = ST_DISARMED;
            timer_n = '0;
          end
        end
`ifdef MONITOR_SEQ_AUTORETRY_EN
        else if (timer == '0) begin
          if (bus.valid && bus.arm) begin
            state_n = ST_ARMING;
            cmp_n   = bus.compare_cfg;
            timer_n = BLANK_LD;
            cnt_n   = '0;
          end else begin
            timer_n = WINDOW_LD;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
`endif
      end
      default: begin
        state_n = ST_DISARMED;
        timer_n = '0;
        win_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // Status flags are registered from the next state so they align with o_state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_DISARMED;
      timer         <= '0;
      win_run       <= 1'b0;
      cnt           <= '0;
      cmp           <= '0;
      monitor_rst_q <= 1'b1;
      ok_q          <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      win_run       <= win_n;
      cnt           <= cnt_n;
      cmp           <= cmp_n;
      monitor_rst_q <= (state_n == ST_DISARMED);
      ok_q          <= (state_n == ST_MONITOR);
      fault_q       <= (state_n == ST_FAULT);
    end
  end

  assign bus.monitor_rst = monitor_rst_q;
  assign bus.compare     = cmp;
  assign bus.ok          = ok_q;
  assign bus.fault       = fault_q;
  assign bus.event_cnt   = cnt;
  assign bus.state       = state;

endmodule

// File: tb/tb_monitor_sequencer.sv
// Directed plus random checking of monitor_sequencer against a cycle-timeline reference model.
module tb_monitor_sequencer;
  localparam int B   = 4;
  localparam int W   = 20;
  localparam int MAX = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   n_assert;
  int   n_fail;

  // reference model: absolute cycle numbers instead of down-counters
  int   m_mode, m_events, m_cmp;
  int   mon_at, win_last, retry_at;
  bit   win_open;

  monitor_seq_if #(.EVT_W(4)) bus ();

  monitor_sequencer #(
    .CNT_W(16), .BLANK_CYCLES(16'd4), .WINDOW_CYCLES(16'd20),
    .EVT_W(4), .MAX_EVENTS(4'd3)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_disarm();
    m_mode = 0; m_events = 0; win_open = 0;
  endtask

  task automatic m_arm(input int c);
    m_mode = 1; m_cmp = int'(bus.compare_cfg); mon_at = c + 1 + B; m_events = 0; win_open = 0;
  endtask

  // Applies the inputs of cycle cyc; afterwards the model holds the values expected in cyc+1.
  task automatic model_step();
    int c;
    c = cyc;
    if (rst) begin
      m_disarm();
      m_cmp = 0;
    end else begin
      case (m_mode)
        0: if (bus.arm) m_arm(c);
        1: if (!bus.arm) m_disarm(); else if (c + 1 == mon_at) m_mode = 2;
        2, 3: begin
          if (!bus.arm) m_disarm();
          else begin
            if (win_open && c == win_last) begin m_events = 0; win_open = 0; end
            if (m_mode == 2 && !bus.valid) begin
              if (!win_open) begin win_open = 1; win_last = c + W; end
              m_events++;
              if (m_events == MAX) begin m_mode = 4; win_open = 0; retry_at = c + 1 + W; end
              else m_mode = 3;
            end else if (m_mode == 3 && bus.valid) m_mode = 2;
          end
        end
        4: begin
          if (bus.clear) begin
            if (bus.arm) m_arm(c); else m_disarm();
          end
`ifdef MONITOR_SEQ_AUTORETRY_EN
          else if (c + 1 == retry_at) begin
            if (bus.valid && bus.arm) m_arm(c); else retry_at += W;
          end
`endif
        end
        default: m_disarm();
      endcase
    end
  endtask

  task automatic check_all();
    chk("state",       bus.state,       m_mode);
    chk("monitor_rst", bus.monitor_rst, (m_mode == 0));
    chk("ok",          bus.ok,          (m_mode == 2));
    chk("fault",       bus.fault,       (m_mode == 4));
    chk("event_cnt",   bus.event_cnt,   m_events);
    chk("compare",     bus.compare,     m_cmp);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  // Three 2-cycle transients with falling edges 4 cycles apart; ends in FAULT.
  task automatic escalate(output int t_fault);
    t_fault = 0;
    for (int k = 0; k < 3; k++) begin
      bus.valid = 1'b0;
      tick();
      if (k == 2) begin
        chk("esc_fault", bus.fault, 1);
        chk("esc_cnt", bus.event_cnt, 3);
        t_fault = cyc;
      end
      tick();
      bus.valid = 1'b1;
      tick();
      tick();
    end
  endtask

  initial begin
    int t0, e, low, tf, guard;
    cyc = 0; n_assert = 0; n_fail = 0;
    m_mode = 0; m_events = 0; m_cmp = 0; win_open = 0; mon_at = 0; win_last = 0; retry_at = 0;
    rst = 1'b1;
    bus.arm = 1'b0; bus.clear = 1'b0; bus.compare_cfg = 4'h0; bus.valid = 1'b1;
    @(negedge clk);
    tick();
    tick();
    chk("reset_rst", bus.monitor_rst, 1);
    chk("reset_state", bus.state, 0);

    // reset then arm
    rst = 1'b0;
    bus.arm = 1'b1; bus.compare_cfg = 4'h5;
    t0 = cyc;
    tick();
    bus.compare_cfg = 4'(($urandom_range(0, 15)));
    chk("arm_compare", bus.compare, 5);
    chk("arm_rst", bus.monitor_rst, 0);
    while (cyc < t0 + 1 + B) tick();
    chk("arm_ok_latency", bus.ok, 1);

    // single transient
    bus.valid = 1'b0;
    e = cyc;
    low = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) chk("single_cnt", bus.event_cnt, 1);
      if (!bus.ok) low++;
    end
    bus.valid = 1'b1;
    tick();
    if (!bus.ok) low++;
    chk("single_low_cycles", low, 3);
    while (cyc < e + W - 1) tick();
    chk("single_cnt_held", bus.event_cnt, 1);
    tick();
    tick();
    chk("single_cnt_cleared", bus.event_cnt, 0);

    // escalation
    escalate(tf);
`ifdef MONITOR_SEQ_AUTORETRY_EN
    guard = 0;
    while (bus.state != 3'd1 && guard < 40) begin tick(); guard++; end
    chk("autoretry_latency", cyc - tf, W);
    repeat (B) tick();
    chk("autoretry_ok", bus.ok, 1);
    escalate(tf);
`else
    guard = 0;
    repeat (100) tick();
    chk("fault_sticky", bus.fault, 1);
`endif

    // clear with arm held
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clear_fault", bus.fault, 0);
    chk("clear_state", bus.state, 1);
    chk("clear_cnt", bus.event_cnt, 0);
    repeat (B) tick();
    chk("clear_ok", bus.ok, 1);

    // disarm in HOLD
    bus.valid = 1'b0;
    tick();
    chk("hold_state", bus.state, 3);
    bus.arm = 1'b0; bus.valid = 1'b1;
    tick();
    chk("disarm_state", bus.state, 0);
    chk("disarm_rst", bus.monitor_rst, 1);
    chk("disarm_cnt", bus.event_cnt, 0);

    // reset while faulted
    bus.arm = 1'b1;
    repeat (B + 1) tick();
    escalate(tf);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_fault", bus.fault, 0);
    chk("rst_compare", bus.compare, 0);
    chk("rst_monitor_rst", bus.monitor_rst, 1);

    // random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) bus.arm = ~bus.arm;
      bus.valid = ($urandom_range(0, 5) != 0);
      bus.clear = ($urandom_range(0, 29) == 0);
      bus.compare_cfg = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
